// File: rtl/bmem_line_arbiter_if.sv
// Cache-side (DFP) and memory-side (bmem) signal bundles for bmem_line_arbiter.
// master drives requests, slave answers them.
interface bmem_line_arbiter_dfp_if #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned LINE_BITS = 256,
  parameter int unsigned ADDR_BITS = 32
);
  logic [NUM_PORTS-1:0][ADDR_BITS-1:0] dfp_addr;
  logic [NUM_PORTS-1:0]                dfp_read;
  logic [NUM_PORTS-1:0]                dfp_write;
  logic [NUM_PORTS-1:0][LINE_BITS-1:0] dfp_wdata;
  logic [LINE_BITS-1:0]                dfp_rdata;
  logic [NUM_PORTS-1:0]                dfp_resp;

  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  dfp_rdata, dfp_resp
  );
  modport slave (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output dfp_rdata, dfp_resp
  );
endinterface

interface bmem_line_arbiter_bmem_if #(
  parameter int unsigned BUS_BITS  = 64,
  parameter int unsigned ADDR_BITS = 32
);
  logic [ADDR_BITS-1:0] bmem_addr;
  logic                 bmem_read;
  logic                 bmem_write;
  logic [BUS_BITS-1:0]  bmem_wdata;
  logic                 bmem_ready;
  logic [ADDR_BITS-1:0] bmem_raddr;
  logic [BUS_BITS-1:0]  bmem_rdata;
  logic                 bmem_rvalid;

  modport master (
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );
  modport slave (
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );
endinterface

// File: rtl/bmem_line_arbiter.sv
// Round-robin arbiter joining NUM_PORTS line-granular cache ports to one burst memory.
// Optional BMEM_RADDR_CHECK_EN: drop read beats whose bmem_raddr line differs from the request.
module bmem_line_arbiter #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned LINE_BITS = 256,
  parameter int unsigned BUS_BITS  = 64,
  parameter int unsigned ADDR_BITS = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  bmem_line_arbiter_dfp_if.slave     dfp,
  bmem_line_arbiter_bmem_if.master   bmem
);

  localparam int unsigned BEATS       = LINE_BITS / BUS_BITS;
  localparam int unsigned BEAT_W      = $clog2(BEATS);
  localparam int unsigned PORT_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned OFFSET_BITS = $clog2(LINE_BITS / 8);
  localparam logic [ADDR_BITS-1:0] ALIGN_MASK =
    ~ADDR_BITS'((64'd1 << OFFSET_BITS) - 64'd1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_BURST, RESP} state_e;

  state_e                state_q, state_d;
  logic [PORT_W-1:0]     port_q, port_d;
  logic [PORT_W-1:0]     rr_q, rr_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [LINE_BITS-1:0]  line_q, line_d;
  logic [LINE_BITS-1:0]  rdata_q, rdata_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;
  logic [ADDR_BITS-1:0]  baddr_q, baddr_d;
  logic [BUS_BITS-1:0]   wdata_q, wdata_d;
  logic [NUM_PORTS-1:0]  resp_q, resp_d;

  logic                  beat_ok;
  logic                  found;
  logic [PORT_W-1:0]     cand;
  int unsigned           idx;

`ifdef BMEM_RADDR_CHECK_EN
  assign beat_ok = bmem.bmem_rvalid && ((bmem.bmem_raddr & ALIGN_MASK) == addr_q);
`else
  logic raddr_unused;
  assign raddr_unused = ^bmem.bmem_raddr;
  assign beat_ok      = bmem.bmem_rvalid;
`endif

  // State register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      port_q  <= '0;
      rr_q    <= '0;
      addr_q  <= '0;
      beat_q  <= '0;
      line_q  <= '0;
      rdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      baddr_q <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
      read_q  <= read_d;
      write_q <= write_d;
      baddr_q <= baddr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
    end
  end

  // Next state, then outputs decoded from the next state so they appear with it
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    rr_d    = rr_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    line_d  = line_q;
    rdata_d = rdata_q;
    read_d  = 1'b0;
    write_d = 1'b0;
    baddr_d = '0;
    wdata_d = '0;
    resp_d  = '0;
    found   = 1'b0;
    cand    = '0;
    idx     = 0;

    unique case (state_q)
      IDLE: begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
          idx = 32'(rr_q) + i;
          if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
          if (!found && (dfp.dfp_read[idx] || dfp.dfp_write[idx])) begin
            found = 1'b1;
            cand  = PORT_W'(idx);
          end
        end
        if (found) begin
          port_d  = cand;
          addr_d  = dfp.dfp_addr[cand] & ALIGN_MASK;
          beat_d  = '0;
          // a port asking for both is written back before its read is served
          state_d = dfp.dfp_write[cand] ? WR_BURST : RD_REQ;
        end
      end
      RD_REQ: begin
        if (bmem.bmem_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (beat_ok) begin
          line_d[32'(beat_q)*BUS_BITS +: BUS_BITS] = bmem.bmem_rdata;
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            beat_d  = '0;
            rdata_d = line_d;
            state_d = RESP;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      WR_BURST: begin
        if (bmem.bmem_ready) begin
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            beat_d  = '0;
            state_d = RESP;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      RESP: begin
        rr_d    = (port_q == PORT_W'(NUM_PORTS - 1)) ? '0 : port_q + PORT_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      RD_REQ: begin
        read_d  = 1'b1;
        baddr_d = addr_d;
      end
      WR_BURST: begin
        write_d = 1'b1;
        baddr_d = addr_d;
        wdata_d = dfp.dfp_wdata[port_d][32'(beat_d)*BUS_BITS +: BUS_BITS];
      end
      RESP: resp_d[port_d] = 1'b1;
      default: ;
    endcase
  end

  assign dfp.dfp_rdata   = rdata_q;
  assign dfp.dfp_resp    = resp_q;
  assign bmem.bmem_addr  = baddr_q;
  assign bmem.bmem_read  = read_q;
  assign bmem.bmem_write = write_q;
  assign bmem.bmem_wdata = wdata_q;

endmodule

// File: tb/tb_bmem_line_arbiter.sv
// Self-checking bench for bmem_line_arbiter: directed steps plus randomized traffic
// checked against a line-level memory model and a round-robin grant model.
module tb_bmem_line_arbiter;
  localparam int unsigned NP    = 2;
  localparam int unsigned LB    = 256;
  localparam int unsigned BB    = 64;
  localparam int unsigned AW    = 32;
  localparam int unsigned BEATS = LB / BB;
  localparam logic [AW-1:0] ALIGN = ~AW'(LB / 8 - 1);

  logic clk;
  logic rst;

  bmem_line_arbiter_dfp_if  #(.NUM_PORTS(NP), .LINE_BITS(LB), .ADDR_BITS(AW)) dfp ();
  bmem_line_arbiter_bmem_if #(.BUS_BITS(BB), .ADDR_BITS(AW)) bmem ();

  bmem_line_arbiter #(
    .NUM_PORTS(NP), .LINE_BITS(LB), .BUS_BITS(BB), .ADDR_BITS(AW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .dfp  (dfp),
    .bmem (bmem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int chk = 0;
  int err = 0;
  int rr  = 0;
  logic [LB-1:0] model_rdata = '0;
  logic [LB-1:0] mem [logic [AW-1:0]];
  logic [NP-1:0] req_rd = '0;
  logic [NP-1:0] req_wr = '0;
  logic [AW-1:0] req_addr [NP];
  logic [LB-1:0] req_line [NP];
`ifdef BMEM_RADDR_CHECK_EN
  bit inject_bad = 1'b0;
`endif

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
    chk++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NP-1:0] onehot(input int p);
    logic [NP-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  function automatic logic [LB-1:0] rand_line();
    logic [LB-1:0] l;
    for (int i = 0; i < LB / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // First requesting port scanning upward from the round-robin pointer
  function automatic int pick();
    int g;
    g = -1;
    for (int i = 0; i < NP; i++) begin
      int j;
      j = (rr + i) % NP;
      if (g < 0 && (req_rd[j] || req_wr[j])) g = j;
    end
    return g;
  endfunction

  task automatic post(input int p, input bit rd, input bit wr,
                      input logic [AW-1:0] a, input logic [LB-1:0] line);
    req_rd[p]   = rd;
    req_wr[p]   = wr;
    req_addr[p] = a;
    req_line[p] = line;
    dfp.dfp_read[p]  = rd;
    dfp.dfp_write[p] = wr;
    dfp.dfp_addr[p]  = a;
    dfp.dfp_wdata[p] = line;
  endtask

  task automatic serve_read(input int p, input logic [AW-1:0] a);
    logic [AW-1:0] la;
    logic [LB-1:0] line;
    int n;
    la = a & ALIGN;
    if (!mem.exists(la)) mem[la] = rand_line();
    line = mem[la];
    n = 0;
    while (bmem.bmem_read !== 1'b1 && n < 20) begin tick(); n++; end
    check("rd_req", LB'(bmem.bmem_read), LB'(1'b1));
    check("rd_addr", LB'(bmem.bmem_addr), LB'(la));
    check("rd_no_write", LB'(bmem.bmem_write), LB'(1'b0));
    repeat ($urandom_range(0, 2)) begin
      tick();
      check("rd_hold", LB'(bmem.bmem_read), LB'(1'b1));
    end
    bmem.bmem_ready = 1'b1;
    tick();
    bmem.bmem_ready = 1'b0;
    check("rd_once", LB'(bmem.bmem_read), LB'(1'b0));
    check("rd_old_data", dfp.dfp_rdata, model_rdata);
    for (int k = 0; k < BEATS; k++) begin
      repeat ($urandom_range(0, 2)) tick();
`ifdef BMEM_RADDR_CHECK_EN
      if (inject_bad && k == 1) begin
        bmem.bmem_rvalid = 1'b1;
        bmem.bmem_raddr  = 32'h0000_3000;
        bmem.bmem_rdata  = {$urandom, $urandom};
        tick();
      end
`endif
      bmem.bmem_rvalid = 1'b1;
      bmem.bmem_raddr  = la;
      bmem.bmem_rdata  = line[k*BB +: BB];
      tick();
      bmem.bmem_rvalid = 1'b0;
      if (k < BEATS - 1) check("rd_early_resp", LB'(dfp.dfp_resp), LB'(0));
    end
    check("rd_resp", LB'(dfp.dfp_resp), LB'(onehot(p)));
    check("rd_data", dfp.dfp_rdata, line);
    model_rdata = line;
    rr = (p + 1) % NP;
    req_rd[p] = 1'b0;
    dfp.dfp_read[p] = 1'b0;
    tick();
    check("rd_resp_pulse", LB'(dfp.dfp_resp), LB'(0));
    check("rd_data_keep", dfp.dfp_rdata, model_rdata);
  endtask

  task automatic serve_write(input int p, input logic [AW-1:0] a, input logic [LB-1:0] line,
                             input int stall_k, input int stall_n);
    logic [AW-1:0] la;
    int n;
    la = a & ALIGN;
    n = 0;
    while (bmem.bmem_write !== 1'b1 && n < 20) begin tick(); n++; end
    check("wr_req", LB'(bmem.bmem_write), LB'(1'b1));
    check("wr_addr", LB'(bmem.bmem_addr), LB'(la));
    for (int k = 0; k < BEATS; k++) begin
      check("wr_valid", LB'(bmem.bmem_write), LB'(1'b1));
      check("wr_no_read", LB'(bmem.bmem_read), LB'(1'b0));
      check("wr_beat", LB'(bmem.bmem_wdata), LB'(line[k*BB +: BB]));
      if (k == stall_k) begin
        repeat (stall_n) begin
          bmem.bmem_ready = 1'b0;
          tick();
          check("wr_stall_valid", LB'(bmem.bmem_write), LB'(1'b1));
          check("wr_stall_beat", LB'(bmem.bmem_wdata), LB'(line[k*BB +: BB]));
        end
      end
      bmem.bmem_ready = 1'b1;
      tick();
    end
    bmem.bmem_ready = 1'b0;
    check("wr_resp", LB'(dfp.dfp_resp), LB'(onehot(p)));
    check("wr_done", LB'(bmem.bmem_write), LB'(1'b0));
    check("wr_rdata_keep", dfp.dfp_rdata, model_rdata);
    mem[la] = line;
    rr = (p + 1) % NP;
    req_wr[p] = 1'b0;
    dfp.dfp_write[p] = 1'b0;
    tick();
    check("wr_resp_pulse", LB'(dfp.dfp_resp), LB'(0));
  endtask

  task automatic serve_pending();
    int g;
    for (int n = 0; n < 4 * NP && (req_rd | req_wr) != '0; n++) begin
      g = pick();
      if (req_wr[g]) serve_write(g, req_addr[g], req_line[g],
                                 $urandom_range(0, BEATS - 1), $urandom_range(0, 3));
      else           serve_read(g, req_addr[g]);
    end
  endtask

  initial begin
    logic [LB-1:0] l;
    logic [AW-1:0] pool [4];
    pool[0] = 32'h0000_1000;
    pool[1] = 32'h0000_2020;
    pool[2] = 32'h0000_4000;
    pool[3] = 32'h0000_5040;

    rst = 1'b1;
    dfp.dfp_addr  = '0;
    dfp.dfp_read  = '0;
    dfp.dfp_write = '0;
    dfp.dfp_wdata = '0;
    bmem.bmem_ready  = 1'b0;
    bmem.bmem_raddr  = '0;
    bmem.bmem_rdata  = '0;
    bmem.bmem_rvalid = 1'b0;
    repeat (3) tick();
    check("rst_read",  LB'(bmem.bmem_read),  LB'(0));
    check("rst_write", LB'(bmem.bmem_write), LB'(0));
    check("rst_addr",  LB'(bmem.bmem_addr),  LB'(0));
    check("rst_wdata", LB'(bmem.bmem_wdata), LB'(0));
    check("rst_resp",  LB'(dfp.dfp_resp),    LB'(0));
    check("rst_rdata", dfp.dfp_rdata,        LB'(0));
    rst = 1'b0;
    tick();
    check("idle_read", LB'(bmem.bmem_read), LB'(0));

    // Port 0 read with recognisable beats
    mem[32'h1000] = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    post(0, 1'b1, 1'b0, 32'h1000, '0);
    serve_read(0, 32'h1000);

    // Port 1 write with a 3-cycle stall on beat 2
    l = {{4{16'hDDDD}}, {4{16'hCCCC}}, {4{16'hBBBB}}, {4{16'hAAAA}}};
    post(1, 1'b0, 1'b1, 32'h2020, l);
    check("rr_before_wr", LB'(pick()), LB'(1));
    serve_write(1, 32'h2020, l, 2, 3);

    // Both ports read repeatedly: grants must alternate
    for (int r = 0; r < 3; r++) begin
      post(0, 1'b1, 1'b0, AW'(32'h8000 + r * 32'h100), '0);
      post(1, 1'b1, 1'b0, AW'(32'h9000 + r * 32'h100), '0);
      serve_pending();
    end

    // Unaligned read maps to its line
    post(0, 1'b1, 1'b0, 32'h1014, '0);
    serve_pending();
    check("unaligned_line", dfp.dfp_rdata, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});

    // Reset during RD_WAIT after two beats
    if (!mem.exists(32'h4000)) mem[32'h4000] = rand_line();
    post(0, 1'b1, 1'b0, 32'h4000, '0);
    for (int n = 0; n < 20 && bmem.bmem_read !== 1'b1; n++) tick();
    bmem.bmem_ready = 1'b1;
    tick();
    bmem.bmem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bmem.bmem_rvalid = 1'b1;
      bmem.bmem_raddr  = 32'h4000;
      bmem.bmem_rdata  = {$urandom, $urandom};
      tick();
    end
    bmem.bmem_rvalid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_read",  LB'(bmem.bmem_read), LB'(0));
    check("midrst_resp",  LB'(dfp.dfp_resp),   LB'(0));
    check("midrst_rdata", dfp.dfp_rdata,       LB'(0));
    check("midrst_addr",  LB'(bmem.bmem_addr), LB'(0));
    repeat (2) begin
      tick();
      check("midrst_no_resp", LB'(dfp.dfp_resp), LB'(0));
    end
    rst = 1'b0;
    rr = 0;
    model_rdata = '0;
    serve_read(0, 32'h4000);

    // Same port asks to write and read: write first, then the read sees it
    l = rand_line();
    post(0, 1'b1, 1'b1, 32'h5040, l);
    serve_pending();
    check("wr_then_rd", dfp.dfp_rdata, l);

    // Randomized mixed traffic
    for (int r = 0; r < 10; r++) begin
      for (int p = 0; p < NP; p++) begin
        int op;
        op = $urandom_range(0, 3);
        post(p, op[0], op[1], pool[$urandom_range(0, 3)] | AW'($urandom_range(0, 31)), rand_line());
      end
      serve_pending();
      tick();
      check("quiet_read",  LB'(bmem.bmem_read),  LB'(0));
      check("quiet_write", LB'(bmem.bmem_write), LB'(0));
    end

`ifdef BMEM_RADDR_CHECK_EN
    // A mistagged beat in the middle of a burst is ignored
    inject_bad = 1'b1;
    post(0, 1'b1, 1'b0, 32'h1000, '0);
    serve_pending();
    inject_bad = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
